// File: rtl/branch_sequencer.sv
// Fetch-PC sequencer: owns the fetch PC, resolves decode-stage branches, drives
// the pipeline flush, handles halt/resume and keeps a circular return-address stack.
module branch_sequencer #(
    parameter int ADDR_W = 12,
    parameter int RAS_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    localparam int CNT_W = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [2:0]        id_kind,
    input  logic [1:0]        id_cond,
    input  logic [7:0]        id_disp,
    input  logic [3:0]        szcv,
    input  logic              halt_req,
    input  logic              resume,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              flush,
    output logic              halted,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [2:0] K_B     = 3'd1;
    localparam logic [2:0] K_BCOND = 3'd2;
    localparam logic [2:0] K_BAL   = 3'd3;
    localparam logic [2:0] K_BR    = 3'd4;

    logic [1:0]        state_r, state_nxt_s;
    logic [ADDR_W-1:0] fetch_pc_r, pc_nxt_s;
    logic [PTR_W-1:0]  wp_r, wp_inc_s, wp_dec_s;
    logic [CNT_W-1:0]  ras_count_r;
    logic              ras_overflow_r, ras_underflow_r;
    logic [ADDR_W-1:0] ras_mem_r [RAS_DEPTH];

    logic [ADDR_W-1:0] target_s, link_s;
    logic              cond_true_s, taken_s, br_empty_s, ras_full_s;
    logic              push_s, pop_s, unf_set_s;
    logic              flag_s, flag_z, flag_v;
    logic              carry_unused_s;

    assign flag_s         = szcv[3];
    assign flag_z         = szcv[2];
    assign flag_v         = szcv[0];
    assign carry_unused_s = szcv[1];

    assign target_s   = id_pc + ADDR_W'($signed(id_disp));
    assign link_s     = id_pc + ADDR_W'(1);
    assign ras_full_s = (ras_count_r == CNT_W'(RAS_DEPTH));
    assign br_empty_s = (id_kind == K_BR) && (ras_count_r == {CNT_W{1'b0}});
    // Pointer wrap is explicit so non-power-of-two depths stay circular.
    assign wp_inc_s   = (wp_r == PTR_W'(RAS_DEPTH - 1)) ? {PTR_W{1'b0}} : wp_r + PTR_W'(1);
    assign wp_dec_s   = (wp_r == {PTR_W{1'b0}}) ? PTR_W'(RAS_DEPTH - 1) : wp_r - PTR_W'(1);

    // Condition evaluation for Bcond.
    always_comb begin
        case (id_cond)
            2'd0:    cond_true_s = flag_z;
            2'd1:    cond_true_s = flag_s ^ flag_v;
            2'd2:    cond_true_s = flag_z | (flag_s ^ flag_v);
            2'd3:    cond_true_s = ~flag_z;
            default: cond_true_s = 1'b0;
        endcase
    end

    // Branch-taken decode; BR only redirects when the RAS has an entry.
    always_comb begin
        case (id_kind)
            K_B:     taken_s = 1'b1;
            K_BCOND: taken_s = cond_true_s;
            K_BAL:   taken_s = 1'b1;
            K_BR:    taken_s = (ras_count_r != {CNT_W{1'b0}});
            default: taken_s = 1'b0;
        endcase
    end

    // Next-state, next-PC and RAS command selection.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = fetch_pc_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        unf_set_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (stall) begin
                    state_nxt_s = ST_RUN;
                end else if (br_empty_s) begin
                    unf_set_s   = 1'b1;
                    state_nxt_s = ST_HALTED;
                end else if (taken_s) begin
                    push_s      = (id_kind == K_BAL);
                    pop_s       = (id_kind == K_BR);
                    pc_nxt_s    = (id_kind == K_BR) ? ras_mem_r[wp_dec_s] : target_s;
                    state_nxt_s = ST_FLUSH;
                end else if (halt_req) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    pc_nxt_s = fetch_pc_r + ADDR_W'(1);
                end
            end
            ST_FLUSH: begin
                if (stall) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    pc_nxt_s    = fetch_pc_r + ADDR_W'(1);
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State, PC, RAS bookkeeping and sticky flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= ST_RUN;
            fetch_pc_r      <= RESET_PC;
            wp_r            <= {PTR_W{1'b0}};
            ras_count_r     <= {CNT_W{1'b0}};
            ras_overflow_r  <= 1'b0;
            ras_underflow_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= pc_nxt_s;
            if (unf_set_s) begin
                ras_underflow_r <= 1'b1;
            end
            if (push_s) begin
                wp_r <= wp_inc_s;
                if (ras_full_s) begin
                    ras_overflow_r <= 1'b1;
                end else begin
                    ras_count_r <= ras_count_r + CNT_W'(1);
                end
            end else if (pop_s) begin
                wp_r        <= wp_dec_s;
                ras_count_r <= ras_count_r - CNT_W'(1);
            end
        end
    end

    // RAS storage; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (push_s) begin
            ras_mem_r[wp_r] <= link_s;
        end
    end

    assign fetch_pc      = fetch_pc_r;
    assign flush         = (state_r == ST_FLUSH);
    assign halted        = (state_r == ST_HALTED);
    assign ras_count     = ras_count_r;
    assign ras_overflow  = ras_overflow_r;
    assign ras_underflow = ras_underflow_r;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed scenarios plus random traffic, all
// compared cycle by cycle against a queue-based behavioural model.
module tb_branch_sequencer;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clock, reset, stall, halt_req, resume;
    logic [ADDR_W-1:0] id_pc;
    logic [2:0]        id_kind;
    logic [1:0]        id_cond;
    logic [7:0]        id_disp;
    logic [3:0]        szcv;
    logic [ADDR_W-1:0] fetch_pc;
    logic              flush, halted, ras_overflow, ras_underflow;
    logic [CNT_W-1:0]  ras_count;

    branch_sequencer #(.ADDR_W(ADDR_W), .RAS_DEPTH(DEPTH), .RESET_PC(12'h000)) dut (
        .clock(clock), .reset(reset), .stall(stall), .id_pc(id_pc), .id_kind(id_kind),
        .id_cond(id_cond), .id_disp(id_disp), .szcv(szcv), .halt_req(halt_req),
        .resume(resume), .fetch_pc(fetch_pc), .flush(flush), .halted(halted),
        .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: plain PC, mode flags and a queue for the RAS.
    logic [ADDR_W-1:0] m_pc;
    bit                m_flush, m_halted, m_ovf, m_unf;
    logic [ADDR_W-1:0] m_ras[$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 12'h000; m_flush = 1'b0; m_halted = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_step();
        bit s, z, v, tk;
        logic [ADDR_W-1:0] dest;
        s = szcv[3]; z = szcv[2]; v = szcv[0];
        if (m_halted) begin
            if (resume) m_halted = 1'b0;
        end else if (stall) begin
            // everything held
        end else if (m_flush) begin
            m_flush = 1'b0;
            m_pc = m_pc + 12'd1;
        end else if (id_kind == 3'd4 && m_ras.size() == 0) begin
            m_unf = 1'b1;
            m_halted = 1'b1;
        end else begin
            tk = 1'b0;
            dest = id_pc + {{4{id_disp[7]}}, id_disp};
            if (id_kind == 3'd1 || id_kind == 3'd3) tk = 1'b1;
            if (id_kind == 3'd2) begin
                if (id_cond == 2'd0) tk = z;
                else if (id_cond == 2'd1) tk = (s != v);
                else if (id_cond == 2'd2) tk = z || (s != v);
                else tk = !z;
            end
            if (id_kind == 3'd3) begin
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_ras.push_back(id_pc + 12'd1);
            end
            if (id_kind == 3'd4) begin
                tk = 1'b1;
                dest = m_ras.pop_back();
            end
            if (tk) begin
                m_pc = dest;
                m_flush = 1'b1;
            end else if (halt_req) begin
                m_halted = 1'b1;
            end else begin
                m_pc = m_pc + 12'd1;
            end
        end
    endtask

    task automatic check_all();
        check_eq("fetch_pc", int'(fetch_pc), int'(m_pc));
        check_eq("flush", int'(flush), int'(m_flush));
        check_eq("halted", int'(halted), int'(m_halted));
        check_eq("ras_count", int'(ras_count), m_ras.size());
        check_eq("ras_overflow", int'(ras_overflow), int'(m_ovf));
        check_eq("ras_underflow", int'(ras_underflow), int'(m_unf));
    endtask

    task automatic idle();
        stall = 1'b0; halt_req = 1'b0; resume = 1'b0; id_kind = 3'd0;
        id_pc = 12'h000; id_cond = 2'd0; id_disp = 8'h00; szcv = 4'b0000;
    endtask

    task automatic branch(input logic [2:0] k, input logic [ADDR_W-1:0] pc,
                          input logic [7:0] d, input logic [1:0] c, input logic [3:0] f);
        id_kind = k; id_pc = pc; id_disp = d; id_cond = c; szcv = f;
    endtask

    // One clock: inputs are already applied; the model steps on the edge and
    // outputs are compared on the following falling edge.
    task automatic cyc();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all();
    endtask

    logic [ADDR_W-1:0] held_pc;

    initial begin
        idle();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        check_all();
        reset = 1'b0;

        // Straight-line fetch after reset.
        check_eq("seq_pc0", int'(fetch_pc), 0);
        for (int i = 1; i < 5; i++) begin
            cyc();
            check_eq("seq_pc", int'(fetch_pc), i);
            check_eq("seq_flush", int'(flush), 0);
        end

        // Backward B and wrapping B.
        branch(3'd1, 12'h010, 8'hF8, 2'd0, 4'b0000); cyc();
        check_eq("b_back_pc", int'(fetch_pc), 12'h008);
        check_eq("b_back_flush", int'(flush), 1);
        idle(); cyc();
        check_eq("b_back_pc2", int'(fetch_pc), 12'h009);
        check_eq("b_back_flush2", int'(flush), 0);
        branch(3'd1, 12'hFFE, 8'h04, 2'd0, 4'b0000); cyc();
        check_eq("b_wrap_pc", int'(fetch_pc), 12'h002);
        idle(); cyc();

        // BLT not taken, BLT taken with stalled FLUSH, BLE taken.
        held_pc = fetch_pc;
        branch(3'd2, 12'h040, 8'h20, 2'd1, 4'b1001); cyc();
        check_eq("blt_nt_flush", int'(flush), 0);
        check_eq("blt_nt_pc", int'(fetch_pc), int'(held_pc + 12'd1));
        branch(3'd2, 12'h040, 8'h20, 2'd1, 4'b1000); cyc();
        check_eq("blt_t_pc", int'(fetch_pc), 12'h060);
        idle(); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_eq("stall_flush", int'(flush), 1);
            check_eq("stall_pc", int'(fetch_pc), 12'h060);
        end
        stall = 1'b0; cyc();
        check_eq("post_stall_pc", int'(fetch_pc), 12'h061);
        branch(3'd2, 12'h070, 8'h05, 2'd2, 4'b0100); cyc();
        check_eq("ble_t_pc", int'(fetch_pc), 12'h075);
        idle(); cyc();

        // BAL then BR.
        branch(3'd3, 12'h020, 8'h10, 2'd0, 4'b0000); cyc();
        check_eq("bal_pc", int'(fetch_pc), 12'h030);
        check_eq("bal_cnt", int'(ras_count), 1);
        idle(); cyc();
        branch(3'd4, 12'h033, 8'h00, 2'd0, 4'b0000); cyc();
        check_eq("br_pc", int'(fetch_pc), 12'h021);
        check_eq("br_cnt", int'(ras_count), 0);
        idle(); cyc();

        // Five nested BALs overflow a 4-deep RAS; pops return LIFO.
        for (int i = 0; i < 5; i++) begin
            branch(3'd3, 12'h100 + 12'(i), 8'h40, 2'd0, 4'b0000); cyc();
            idle(); cyc();
        end
        check_eq("ovf_cnt", int'(ras_count), 4);
        check_eq("ovf_flag", int'(ras_overflow), 1);
        for (int i = 0; i < 4; i++) begin
            branch(3'd4, 12'h200, 8'h00, 2'd0, 4'b0000); cyc();
            check_eq("lifo_pc", int'(fetch_pc), 12'h105 - 12'(i));
            idle(); cyc();
        end
        held_pc = fetch_pc;
        branch(3'd4, 12'h200, 8'h00, 2'd0, 4'b0000); cyc();
        check_eq("unf_flag", int'(ras_underflow), 1);
        check_eq("unf_halted", int'(halted), 1);
        check_eq("unf_pc", int'(fetch_pc), int'(held_pc));
        idle(); resume = 1'b1; cyc();
        resume = 1'b0; cyc();

        // Halt with toggling decode, resume, then async reset while halted.
        halt_req = 1'b1; cyc();
        check_eq("halt_set", int'(halted), 1);
        held_pc = fetch_pc;
        halt_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            id_kind = 3'($urandom_range(0, 7)); stall = 1'(i % 2); cyc();
            check_eq("halt_hold_pc", int'(fetch_pc), int'(held_pc));
        end
        idle(); resume = 1'b1; cyc();
        check_eq("resume_halted", int'(halted), 0);
        check_eq("resume_pc", int'(fetch_pc), int'(held_pc));
        resume = 1'b0; cyc();
        check_eq("resume_inc", int'(fetch_pc), int'(held_pc + 12'd1));
        halt_req = 1'b1; cyc();
        halt_req = 1'b0;
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clock); reset = 1'b0;
        cyc();

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            stall    = ($urandom_range(0, 4) == 0);
            halt_req = ($urandom_range(0, 19) == 0);
            resume   = ($urandom_range(0, 2) == 0);
            id_kind  = 3'($urandom_range(0, 7));
            id_cond  = 2'($urandom_range(0, 3));
            id_disp  = 8'($urandom);
            id_pc    = 12'($urandom);
            szcv     = 4'($urandom);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
